udp_tx_arb: RTL and testbench



---
 rtl/udp_tx_arb.sv | 180 ++++++++++++++++++
 tb/tb_udp_tx_arb.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arb.sv
// Round-robin UDP transmit arbiter: builds the 64-bit UDP header for the granted requester, then forwards its payload.
// Optional per-requester datagram and drop counters are enabled by defining UDP_TX_ARB_STATS_EN.
module udp_tx_arb #(
  parameter int          NREQ     = 4,
  parameter logic [15:0] MAX_PLEN = 16'd65527
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    s_req,
  input  logic [NREQ*16-1:0] s_sport,
  input  logic [NREQ*16-1:0] s_dport,
  input  logic [NREQ*16-1:0] s_plen,
  output logic [NREQ-1:0]    s_grant,
  input  logic [NREQ*64-1:0] s_tdata,
  input  logic [NREQ-1:0]    s_tvalid,
  input  logic [NREQ-1:0]    s_tlast,
  output logic [NREQ-1:0]    s_tready,
  output logic [63:0]        m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic               err_oversize,
  output logic               busy
`ifdef UDP_TX_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0] pkt_cnt,
  output logic [31:0]        drop_cnt
`endif
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] last_q;
  logic [15:0]     sport_q, dport_q, plen_q;
  logic            err_q;

  logic            arb_found;
  logic [IDXW-1:0] arb_idx;
  logic [IDXW-1:0] cand;
  logic [15:0]     arb_sport, arb_dport, arb_plen;
  logic            arb_over;
  logic            take;

  logic [63:0]     cur_tdata;
  logic            cur_tvalid, cur_tlast;

  // last_q doubles as the owner index while busy, so the search restarts just past the previous winner.
  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDXW'((int'(last_q) + k) % NREQ);
      if (!arb_found && s_req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign arb_sport  = s_sport[int'(arb_idx)*16 +: 16];
  assign arb_dport  = s_dport[int'(arb_idx)*16 +: 16];
  assign arb_plen   = s_plen[int'(arb_idx)*16 +: 16];
  assign arb_over   = arb_plen > MAX_PLEN;
  assign take       = (state_q == S_IDLE) && arb_found;

  assign cur_tdata  = s_tdata[int'(last_q)*64 +: 64];
  assign cur_tvalid = s_tvalid[last_q];
  assign cur_tlast  = s_tlast[last_q];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IDXW'(NREQ - 1);
      sport_q <= '0;
      dport_q <= '0;
      plen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (take) begin
        last_q  <= arb_idx;
        sport_q <= arb_sport;
        dport_q <= arb_dport;
        plen_q  <= arb_plen;
        err_q   <= arb_over;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) state_d = arb_over ? S_DRAIN : S_HDR;
      end
      S_HDR: begin
        if (m_tready) state_d = (plen_q == 16'd0) ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (cur_tvalid && m_tready && cur_tlast) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (cur_tvalid && cur_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_grant  = '0;
    s_tready = '0;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    case (state_q)
      S_HDR: begin
        s_grant[last_q] = 1'b1;
        m_tvalid        = 1'b1;
        m_tdata         = {sport_q, dport_q, plen_q + 16'd8, 16'h0000};
        m_tlast         = (plen_q == 16'd0);
      end
      S_PAYLOAD: begin
        s_grant[last_q]  = 1'b1;
        m_tdata          = cur_tdata;
        m_tvalid         = cur_tvalid;
        m_tlast          = cur_tlast;
        s_tready[last_q] = m_tready;
      end
      S_DRAIN: begin
        s_grant[last_q]  = 1'b1;
        s_tready[last_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign err_oversize = err_q;

`ifdef UDP_TX_ARB_STATS_EN
  logic [31:0] pkt_cnt_q [NREQ];
  logic [31:0] drop_cnt_q;
  logic        pkt_done;

  // A datagram is done when its final beat leaves: a zero-length header, or the last payload beat.
  assign pkt_done = ((state_q == S_HDR) && m_tready && (plen_q == 16'd0)) ||
                    ((state_q == S_PAYLOAD) && cur_tvalid && m_tready && cur_tlast);

  // NOTE: this counter array is small and must read 0 after reset, so it is reset explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) pkt_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pkt_done) pkt_cnt_q[last_q] <= pkt_cnt_q[last_q] + 32'd1;
      if (err_q) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < NREQ; i++) pkt_cnt[i*32 +: 32] = pkt_cnt_q[i];
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_udp_tx_arb.sv
// Self-checking bench for udp_tx_arb: randomized requesters and backpressure against a queue-based reference model.
// Counter checks are compiled in when UDP_TX_ARB_STATS_EN is defined.
module tb_udp_tx_arb;

  localparam int          NREQ     = 4;
  localparam logic [15:0] MAX_PLEN = 16'd65527;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    s_req;
  logic [NREQ*16-1:0] s_sport, s_dport, s_plen;
  logic [NREQ-1:0]    s_grant;
  logic [NREQ*64-1:0] s_tdata;
  logic [NREQ-1:0]    s_tvalid, s_tlast, s_tready;
  logic [63:0]        m_tdata;
  logic               m_tvalid, m_tlast, m_tready;
  logic               err_oversize, busy;
`ifdef UDP_TX_ARB_STATS_EN
  logic [NREQ*32-1:0] pkt_cnt;
  logic [31:0]        drop_cnt;
`endif

  always #5 clk = ~clk;

  udp_tx_arb #(.NREQ(NREQ), .MAX_PLEN(MAX_PLEN)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_sport(s_sport), .s_dport(s_dport), .s_plen(s_plen),
    .s_grant(s_grant),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .err_oversize(err_oversize), .busy(busy)
`ifdef UDP_TX_ARB_STATS_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] plen;
    int          nbeats;
    int          base;
    bit          over;
  } pkt_t;

  pkt_t        pkts[$];
  logic [63:0] beat_mem[$];
  int          pq[NREQ][$];
  logic [64:0] exp_q[$];
  int          grant_log[$];

  int total = 0;
  int bad   = 0;

  int active, act_pkt, act_beat, model_last, in_hs_cnt, err_seen, drop_model;
  int pkt_model[NREQ];
  bit act_over, hdr_pending, expect_idle, stall_prev, cur_valid;
  logic            snap_busy;
  logic [NREQ-1:0] snap_req;
  logic [63:0]     data_prev;
  logic            last_prev;
  int ready_pct, valid_pct;

  task automatic add_pkt(input int r, input logic [15:0] sp, input logic [15:0] dp,
                         input logic [15:0] pl, input int nb);
    pkt_t p;
    p.sport  = sp;
    p.dport  = dp;
    p.plen   = pl;
    p.nbeats = nb;
    p.base   = beat_mem.size();
    p.over   = (pl > MAX_PLEN);
    for (int b = 0; b < nb; b++) beat_mem.push_back({$urandom(), $urandom()});
    pkts.push_back(p);
    pq[r].push_back(pkts.size() - 1);
  endtask

  task automatic model_clear();
    pkts.delete();
    beat_mem.delete();
    for (int r = 0; r < NREQ; r++) begin
      pq[r].delete();
      pkt_model[r] = 0;
    end
    exp_q.delete();
    grant_log.delete();
    active      = -1;
    act_pkt     = 0;
    act_beat    = 0;
    act_over    = 0;
    hdr_pending = 0;
    expect_idle = 0;
    stall_prev  = 0;
    cur_valid   = 0;
    model_last  = NREQ - 1;
    in_hs_cnt   = 0;
    err_seen    = 0;
    drop_model  = 0;
    snap_busy   = 1'b0;
    snap_req    = '0;
    data_prev   = '0;
    last_prev   = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_req    = '0;
    s_sport  = '0;
    s_dport  = '0;
    s_plen   = '0;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Requesters keep s_req high while they hold a packet; the owner drives its beats until accepted.
  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      s_req[r] = (pq[r].size() > 0);
      if (pq[r].size() > 0) begin
        s_sport[r*16 +: 16] = pkts[pq[r][0]].sport;
        s_dport[r*16 +: 16] = pkts[pq[r][0]].dport;
        s_plen[r*16 +: 16]  = pkts[pq[r][0]].plen;
      end else begin
        s_sport[r*16 +: 16] = 16'($urandom());
        s_dport[r*16 +: 16] = 16'($urandom());
        s_plen[r*16 +: 16]  = 16'($urandom());
      end
      s_tdata[r*64 +: 64] = {$urandom(), $urandom()};
    end
    s_tvalid = '0;
    s_tlast  = '0;
    if (active >= 0 && act_beat < pkts[act_pkt].nbeats) begin
      if (!cur_valid) cur_valid = ($urandom_range(99) < valid_pct);
      s_tvalid[active]            = cur_valid;
      s_tdata[active*64 +: 64]    = beat_mem[pkts[act_pkt].base + act_beat];
      s_tlast[active]             = (act_beat == pkts[act_pkt].nbeats - 1);
    end
    m_tready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic start_pkt(input int w);
    int k;
    logic [15:0] len;
    k = pq[w].pop_front();
    active      = w;
    act_pkt     = k;
    act_beat    = 0;
    cur_valid   = 0;
    act_over    = pkts[k].over;
    hdr_pending = !pkts[k].over;
    grant_log.push_back(w);
    if (!pkts[k].over) begin
      len = pkts[k].plen + 16'd8;
      exp_q.push_back({pkts[k].plen == 16'd0, pkts[k].sport, pkts[k].dport, len, 16'h0000});
      for (int b = 0; b < pkts[k].nbeats; b++)
        exp_q.push_back({b == pkts[k].nbeats - 1, beat_mem[pkts[k].base + b]});
    end
  endtask

  task automatic sample();
    logic [NREQ-1:0] exp_grant;
    logic [NREQ-1:0] exp_tready;
    logic [64:0]     e;
    bit              err_exp;
    int              w;
    exp_grant = '0;
    err_exp   = 0;
`ifdef UDP_TX_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) begin
      total++;
      if (pkt_cnt[i*32 +: 32] !== 32'(pkt_model[i])) begin
        bad++;
        $display("FAIL pkt_cnt[%0d]: got %0d want %0d", i, pkt_cnt[i*32 +: 32], pkt_model[i]);
      end
    end
    total++;
    if (drop_cnt !== 32'(drop_model)) begin
      bad++;
      $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, drop_model);
    end
`endif
    if (expect_idle) begin
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_gap: busy got %b want 0", busy);
      end
      expect_idle = 0;
    end
    if (!snap_busy) begin
      if (snap_req != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && snap_req[(model_last + k) % NREQ]) w = (model_last + k) % NREQ;
        model_last   = w;
        start_pkt(w);
        err_exp      = act_over;
        exp_grant[w] = 1'b1;
      end
    end else if (active >= 0) begin
      exp_grant[active] = 1'b1;
    end
    total++;
    if (s_grant !== exp_grant) begin
      bad++;
      $display("FAIL grant: got %b want %b", s_grant, exp_grant);
    end
    total++;
    if (err_oversize !== err_exp) begin
      bad++;
      $display("FAIL err_oversize: got %b want %b", err_oversize, err_exp);
    end
    if (err_oversize === 1'b1) err_seen++;
    if (err_exp) drop_model++;

    exp_tready = '0;
    if (active >= 0 && !hdr_pending && (act_over || m_tready)) exp_tready[active] = 1'b1;
    total++;
    if (s_tready !== exp_tready) begin
      bad++;
      $display("FAIL s_tready: got %b want %b", s_tready, exp_tready);
    end
    if (active < 0 || act_over) begin
      total++;
      if (m_tvalid !== 1'b0) begin
        bad++;
        $display("FAIL m_tvalid_quiet: got %b want 0", m_tvalid);
      end
    end
    if (stall_prev) begin
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== data_prev || m_tlast !== last_prev) begin
        bad++;
        $display("FAIL hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 m_tvalid, m_tdata, m_tlast, data_prev, last_prev);
      end
    end

    if (active >= 0 && s_tvalid[active] && s_tready[active] === 1'b1) begin
      act_beat++;
      in_hs_cnt++;
      cur_valid = 0;
      if (act_over && act_beat == pkts[act_pkt].nbeats) begin
        active      = -1;
        expect_idle = 1;
      end
    end
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_beat: got unexpected beat %h want none", m_tdata);
      end else begin
        e = exp_q.pop_front();
        if ({m_tlast, m_tdata} !== e) begin
          bad++;
          $display("FAIL out_beat: got l=%b d=%h want l=%b d=%h", m_tlast, m_tdata, e[64], e[63:0]);
        end
        hdr_pending = 0;
        if (e[64] && active >= 0) begin
          pkt_model[active]++;
          active      = -1;
          expect_idle = 1;
        end
      end
    end

    stall_prev = (m_tvalid === 1'b1) && (m_tready === 1'b0);
    data_prev  = m_tdata;
    last_prev  = m_tlast;
    snap_busy  = busy;
    snap_req   = s_req;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1 drive();
  endtask

  function automatic bit all_done();
    bit d;
    d = (active < 0) && !expect_idle && (exp_q.size() == 0);
    for (int r = 0; r < NREQ; r++) if (pq[r].size() > 0) d = 0;
    return d;
  endfunction

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    drive();
    while (!all_done() && n < budget) begin
      step();
      n++;
    end
    total++;
    if (!all_done()) begin
      bad++;
      $display("FAIL timeout: got %0d cycles without completion want done within %0d", n, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (s_grant !== '0)      begin bad++; $display("FAIL reset_grant: got %b want 0", s_grant); end
    total++; if (s_tready !== '0)     begin bad++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    total++; if (m_tvalid !== 1'b0)   begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    total++; if (m_tlast !== 1'b0)    begin bad++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    total++; if (m_tdata !== 64'h0)   begin bad++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    total++; if (err_oversize !== 0)  begin bad++; $display("FAIL reset_err: got %b want 0", err_oversize); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    ready_pct = 100;
    valid_pct = 100;
    add_pkt(2, 16'h1234, 16'h5678, 16'd16, 2);
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    total++; if (s_grant !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", s_grant); end
    total++; if (m_tvalid !== 1'b1)   begin bad++; $display("FAIL single_hvalid: got %b want 1", m_tvalid); end
    total++;
    if (m_tdata !== 64'h1234_5678_0018_0000) begin
      bad++;
      $display("FAIL single_hdr: got %h want 1234567800180000", m_tdata);
    end
    total++; if (m_tlast !== 1'b0)    begin bad++; $display("FAIL single_hlast: got %b want 0", m_tlast); end
    sample();
    @(posedge clk);
    #1;
    run_until_done(50);
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [15:0] pl;
    do_reset();
    ready_pct = 100;
    valid_pct = 100;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NREQ; r++) begin
        pl = 16'($urandom_range(24, 1));
        add_pkt(r, 16'($urandom()), 16'($urandom()), pl, (int'(pl) + 7) / 8);
      end
    run_until_done(200);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (grant_log.size() <= i || grant_log[i] !== exp_order[i]) begin
        bad++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i,
                 (grant_log.size() > i) ? grant_log[i] : -1, exp_order[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    ready_pct = 100;
    valid_pct = 100;
    add_pkt(1, 16'($urandom()), 16'($urandom()), 16'd0, 0);
    add_pkt(1, 16'($urandom()), 16'($urandom()), 16'd8, 1);
    run_until_done(50);
    total++;
    if (grant_log.size() != 2) begin
      bad++;
      $display("FAIL zero_len_count: got %0d want 2", grant_log.size());
    end
  endtask

  task automatic test_oversize();
    do_reset();
    ready_pct = 100;
    valid_pct = 100;
    add_pkt(3, 16'hAAAA, 16'hBBBB, 16'd65528, 3);
    add_pkt(0, 16'hCCCC, 16'hDDDD, MAX_PLEN, 2);
    run_until_done(100);
    total++;
    if (err_seen != 1) begin
      bad++;
      $display("FAIL oversize_pulses: got %0d want 1", err_seen);
    end
`ifdef UDP_TX_ARB_STATS_EN
    total++;
    if (drop_cnt !== 32'd1) begin
      bad++;
      $display("FAIL oversize_drop_cnt: got %0d want 1", drop_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    int r;
    logic [15:0] pl;
    do_reset();
    ready_pct = 50;
    valid_pct = 70;
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(NREQ - 1);
      if ($urandom_range(7) == 0) begin
        pl = 16'($urandom_range(65535, 65528));
        add_pkt(r, 16'($urandom()), 16'($urandom()), pl, $urandom_range(3, 1));
      end else begin
        pl = 16'($urandom_range(80));
        add_pkt(r, 16'($urandom()), 16'($urandom()), pl, (int'(pl) + 7) / 8);
      end
    end
    run_until_done(5000);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    ready_pct = 100;
    valid_pct = 100;
    add_pkt(2, 16'h0102, 16'h0304, 16'd32, 4);
    drive();
    n = 0;
    while (in_hs_cnt < 1 && n < 50) begin
      step();
      n++;
    end
    total++;
    if (in_hs_cnt < 1) begin
      bad++;
      $display("FAIL reset_mid_reach: got %0d beats want 1", in_hs_cnt);
    end
    #2 rst = 1'b1;
    #1;
    total++; if (s_grant !== '0)     begin bad++; $display("FAIL abort_grant: got %b want 0", s_grant); end
    total++; if (s_tready !== '0)    begin bad++; $display("FAIL abort_tready: got %b want 0", s_tready); end
    total++; if (m_tvalid !== 1'b0)  begin bad++; $display("FAIL abort_tvalid: got %b want 0", m_tvalid); end
    total++; if (m_tlast !== 1'b0)   begin bad++; $display("FAIL abort_tlast: got %b want 0", m_tlast); end
    total++; if (m_tdata !== 64'h0)  begin bad++; $display("FAIL abort_tdata: got %h want 0", m_tdata); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    do_reset();
    add_pkt(3, 16'($urandom()), 16'($urandom()), 16'd8, 1);
    add_pkt(0, 16'($urandom()), 16'($urandom()), 16'd8, 1);
    run_until_done(50);
    total++;
    if (grant_log.size() == 0 || grant_log[0] !== 0) begin
      bad++;
      $display("FAIL abort_first: got %0d want 0", (grant_log.size() > 0) ? grant_log[0] : -1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    ready_pct = 100;
    valid_pct = 100;
    model_clear();
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_oversize();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
